// File: rtl/gate_array_pkg.sv
// Shared sequencer definitions: Johnson code widths, phase encode/decode helpers.
package gate_array_pkg;

  localparam int unsigned SEQ_W      = 8;
  localparam int unsigned NUM_PHASES = 16;
  localparam int unsigned PHASE_W    = 4;

  typedef struct packed {
    logic               valid;
    logic [PHASE_W-1:0] phase;
  } seq_dec_t;

  // Phases 0..7 fill ones from bit 0 upward; phases 8..15 drain them from bit 0 upward.
  function automatic logic [SEQ_W-1:0] seq_code(input logic [PHASE_W-1:0] phase);
    logic [SEQ_W-1:0] code;
    int p;
    code = '0;
    p    = int'(phase);
    for (int i = 0; i < int'(SEQ_W); i++) begin
      if (p < int'(SEQ_W)) code[i] = (i < p);
      else                 code[i] = (i >= (p - int'(SEQ_W)));
    end
    return code;
  endfunction

  function automatic seq_dec_t seq_phase(input logic [SEQ_W-1:0] s);
    seq_dec_t dec;
    dec = '0;
    for (int k = 0; k < int'(NUM_PHASES); k++) begin
      if (s == seq_code(PHASE_W'(k))) begin
        dec.valid = 1'b1;
        dec.phase = PHASE_W'(k);
      end
    end
    return dec;
  endfunction

endpackage

// File: rtl/sequence_generator_seq_code_check.sv
// Combinational Johnson-code checker: flags illegal patterns and yields the phase index.
module seq_code_check
  import gate_array_pkg::*;
(
  input  logic [SEQ_W-1:0]   i_s,
  output logic               o_valid_c,
  output logic [PHASE_W-1:0] o_phase_c
);

  seq_dec_t w_dec;

  always_comb begin
    w_dec     = seq_phase(i_s);
    o_valid_c = w_dec.valid;
    o_phase_c = w_dec.valid ? w_dec.phase : '0;
  end

endmodule

// File: rtl/sequence_generator.sv
// 16-phase Johnson master sequencer with resync, illegal-code recovery, lock tracking and test load.
module sequence_generator
  import gate_array_pkg::*;
#(
  parameter int unsigned SYNC_PHASE = 0,
  parameter int unsigned LOCK_REVS  = 2
) (
  input  logic               CLK_n,
  input  logic               RESET_n,
  input  logic               SYNC_n,
  input  logic               TEST_LOAD,
  input  logic [SEQ_W-1:0]   TEST_S,
  output logic [SEQ_W-1:0]   S,
  output logic [PHASE_W-1:0] PHASE,
  output logic               CYCLE_START,
  output logic               LOCKED,
  output logic               SEQ_ERR
);

  localparam logic [SEQ_W-1:0]   SYNC_CODE = seq_code(PHASE_W'(SYNC_PHASE));
  localparam logic [SEQ_W-1:0]   WRAP_CODE = seq_code(PHASE_W'(NUM_PHASES - 1));
  localparam logic [PHASE_W-1:0] LOCK_TGT  = PHASE_W'(LOCK_REVS);

  logic [SEQ_W-1:0]   r_s;
  logic [PHASE_W-1:0] r_lock_cnt;
  logic               r_locked;
  logic               r_seq_err;

  logic               w_valid;
  logic [PHASE_W-1:0] w_phase;
  logic [SEQ_W-1:0]   w_s_next;
  logic [PHASE_W-1:0] w_cnt_next;
  logic               w_locked_next;
  logic               w_err_next;
  logic               w_clr;
  logic               w_wrap;

  seq_code_check u_code_check (
    .i_s       (r_s),
    .o_valid_c (w_valid),
    .o_phase_c (w_phase)
  );

  // Next-state selection in priority order: test load, resync, recovery, advance.
  always_comb begin
    w_s_next      = {r_s[SEQ_W-2:0], ~r_s[SEQ_W-1]};
    w_cnt_next    = r_lock_cnt;
    w_err_next    = ~w_valid;
    w_clr         = TEST_LOAD | ~SYNC_n | ~w_valid;
    w_wrap        = (r_s == WRAP_CODE);
    w_locked_next = 1'b0;

    if (TEST_LOAD)     w_s_next = TEST_S;
    else if (!SYNC_n)  w_s_next = SYNC_CODE;
    else if (!w_valid) w_s_next = '0;

    // Any discontinuity restarts the revolution count.
    if (w_clr)                              w_cnt_next = '0;
    else if (w_wrap && r_lock_cnt != LOCK_TGT) w_cnt_next = r_lock_cnt + PHASE_W'(1);

    w_locked_next = (w_cnt_next == LOCK_TGT);
  end

  always_ff @(posedge CLK_n or negedge RESET_n) begin
    if (!RESET_n) begin
      r_s        <= '0;
      r_lock_cnt <= '0;
      r_locked   <= 1'b0;
      r_seq_err  <= 1'b0;
    end else begin
      r_s        <= w_s_next;
      r_lock_cnt <= w_cnt_next;
      r_locked   <= w_locked_next;
      r_seq_err  <= w_err_next;
    end
  end

  assign S           = r_s;
  assign PHASE       = w_phase;
  assign CYCLE_START = w_valid & (w_phase == '0);
  assign LOCKED      = r_locked;
  assign SEQ_ERR     = r_seq_err;

endmodule
